// File: rtl/arbitro_respuesta_pkg.sv
// Shared types and helpers for the result-word arbiter.
package arbitro_respuesta_pkg;

  // Arbiter FSM: idle/arbitrate, grant held, one dead cycle after a grant.
  typedef enum logic [1:0] {
    LIBRE     = 2'd0,
    CONCEDIDO = 2'd1,
    LIBERAR   = 2'd2
  } estado_t;

  // Default width of the shared datapath result word.
  localparam int ANCHO_DEF = 16;

  // Index width for a range of n values, never below one bit.
  function automatic int ancho_indice(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arbitro_respuesta_prioridad_circular.sv
// Circular priority picker: first set request bit at or after puntero,
// wrapping modulo NUM_SOL.
module prioridad_circular
  import arbitro_respuesta_pkg::*;
#(
  parameter  int NUM_SOL = 4,
  localparam int PW      = ancho_indice(NUM_SOL)
) (
  input  logic [NUM_SOL-1:0] Solicitud,
  input  logic [PW-1:0]      puntero,
  output logic               hay,
  output logic [PW-1:0]      indice
);

  localparam int unsigned N = NUM_SOL;

  int unsigned pos;

  // Scan every requester once, starting from the pointer; keep the first hit.
  always_comb begin
    hay    = 1'b0;
    indice = '0;
    pos    = 0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = (32'(puntero) + i) % N;
      if (!hay && Solicitud[pos]) begin
        hay    = 1'b1;
        indice = PW'(pos);
      end
    end
  end

endmodule

// File: rtl/arbitro_respuesta.sv
// Round-robin arbiter sharing one datapath result word among NUM_SOL
// requesters. The granted requester sees a registered copy of Respuesta
// on Dato, qualified by Valido, until it drops its request or the grant
// times out after MAX_CICLOS cycles.
module arbitro_respuesta
  import arbitro_respuesta_pkg::*;
#(
  parameter int NUM_SOL    = 4,
  parameter int MAX_CICLOS = 8,
  parameter int ANCHO      = ANCHO_DEF
) (
  input  logic               Reloj,
  input  logic               Reset,
  input  logic [NUM_SOL-1:0] Solicitud,
  input  logic [ANCHO-1:0]   Respuesta,
  output logic [NUM_SOL-1:0] Concesion,
  output logic [ANCHO-1:0]   Dato,
  output logic               Valido,
  output logic               Ocupado,
  output logic               Expirado
);

  localparam int PW = ancho_indice(NUM_SOL);
  localparam int CW = ancho_indice(MAX_CICLOS);

  localparam logic [CW-1:0] CONT_FIN = CW'(MAX_CICLOS - 1);
  localparam logic [PW-1:0] IDX_ULT  = PW'(NUM_SOL - 1);

  estado_t       estado;
  logic [PW-1:0] puntero;
  logic [PW-1:0] puntero_sig;
  logic [PW-1:0] indice_act;
  logic [PW-1:0] indice_sel;
  logic          hay;
  logic [CW-1:0] contador;
  logic          activo_sigue;
  logic          fin_tiempo;

  prioridad_circular #(
    .NUM_SOL (NUM_SOL)
  ) u_prioridad (
    .Solicitud (Solicitud),
    .puntero   (puntero),
    .hay       (hay),
    .indice    (indice_sel)
  );

  // Concesion is one-hot, so masking it with the requests yields exactly
  // the granted requester's bit without indexing by the stored index.
  always_comb begin
    activo_sigue = |(Solicitud & Concesion);
    fin_tiempo   = (contador == CONT_FIN);
  end

  // Next pointer: the requester after the current grant, wrapping at NUM_SOL.
  always_comb begin
    if (indice_act == IDX_ULT) begin
      puntero_sig = '0;
    end else begin
      puntero_sig = indice_act + PW'(1);
    end
  end

  // Arbiter FSM with registered grant, data and status outputs.
  always_ff @(posedge Reloj) begin
    if (Reset) begin
      estado     <= LIBRE;
      puntero    <= '0;
      indice_act <= '0;
      contador   <= '0;
      Concesion  <= '0;
      Dato       <= '0;
      Valido     <= 1'b0;
      Ocupado    <= 1'b0;
      Expirado   <= 1'b0;
    end else begin
      Expirado <= 1'b0;
      case (estado)
        LIBRE: begin
          if (hay) begin
            Concesion  <= NUM_SOL'(1) << indice_sel;
            indice_act <= indice_sel;
            contador   <= '0;
            Ocupado    <= 1'b1;
            estado     <= CONCEDIDO;
          end
        end
        CONCEDIDO: begin
          Dato     <= Respuesta;
          contador <= contador + CW'(1);
          if (!activo_sigue || fin_tiempo) begin
            // A drop on the limit cycle wins over the timeout: Expirado
            // only pulses when the requester was still asking.
            Expirado  <= activo_sigue;
            Concesion <= '0;
            Valido    <= 1'b0;
            Ocupado   <= 1'b0;
            puntero   <= puntero_sig;
            estado    <= LIBERAR;
          end else begin
            Valido <= 1'b1;
          end
        end
        LIBERAR: begin
          estado <= LIBRE;
        end
        default: begin
          estado <= LIBRE;
        end
      endcase
    end
  end

  // Grant vector must never carry more than one bit.
  always_ff @(posedge Reloj) begin
    if (!Reset) begin
      assert ($onehot0(Concesion));
    end
  end

endmodule
